dirty_tracker: RTL and testbench

//   Parametrised per-set, per-way dirty-bit store for the write-back data cache.

---
 rtl/dirty_tracker_if.sv | 39 +++
 rtl/dirty_tracker.sv | 166 ++++++++++++++++
 tb/tb_dirty_tracker.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dirty_tracker_if.sv
// Bus bundle between the dcache FSM (master) and the dirty-bit tracker (slave).
interface dirty_tracker_if #(
    parameter int unsigned SETS = 64,
    parameter int unsigned WAYS = 2
);
    localparam int unsigned SW = $clog2(SETS);
    localparam int unsigned CW = $clog2(SETS + 1);

    // write / read port
    logic [WAYS-1:0]    we;
    logic [SW-1:0]      w_addr;
    logic               w_data;
    logic [SW-1:0]      r_addr;
    logic [WAYS-1:0]    r_mask;
    logic [WAYS*CW-1:0] way_cnt;
    logic               any_dirty;

    // flush walker
    logic               flush_req;
    logic [WAYS-1:0]    flush_sel;
    logic               flush_valid;
    logic               flush_ready;
    logic [SW-1:0]      flush_set;
    logic [WAYS-1:0]    flush_mask;
    logic               flush_busy;
    logic               flush_done;

    modport master (
        output we, w_addr, w_data, r_addr, flush_req, flush_sel, flush_ready,
        input  r_mask, way_cnt, any_dirty, flush_valid, flush_set, flush_mask,
               flush_busy, flush_done
    );

    modport slave (
        input  we, w_addr, w_data, r_addr, flush_req, flush_sel, flush_ready,
        output r_mask, way_cnt, any_dirty, flush_valid, flush_set, flush_mask,
               flush_busy, flush_done
    );
endinterface

// File: rtl/dirty_tracker.sv
// Per-set, per-way dirty-bit store with exact per-way dirty counters and a
// flush walker that hands dirty sets to the dcache writeback FSM.
module dirty_tracker #(
    parameter int unsigned SETS = 64,
    parameter int unsigned WAYS = 2
) (
    input  logic           clk,
    input  logic           rst,
    dirty_tracker_if.slave bus
);
    localparam int unsigned   SW       = $clog2(SETS);
    localparam int unsigned   CW       = $clog2(SETS + 1);
    localparam logic [SW-1:0] LAST_SET = SW'(SETS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        OFFER = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [WAYS-1:0] bits     [SETS];
    logic [CW-1:0]   cnt      [WAYS];
    logic [CW-1:0]   cnt_next [WAYS];

    state_t          state;
    logic [SW-1:0]   ptr;
    logic [WAYS-1:0] sel;

    logic [WAYS-1:0] scan_mask;
    logic            sel_dirty;
    logic            handshake;
    logic [WAYS-1:0] old_w;
    logic [WAYS-1:0] old_c;
    logic [WAYS-1:0] up;
    logic [WAYS-1:0] dn_w;
    logic [WAYS-1:0] dn_c;

    // Array lookups: read port, walker probe, and the old values of the bits
    // touched by this cycle's write and handshake clear.
    always_comb begin
        bus.r_mask = bits[bus.r_addr];
        scan_mask  = bits[ptr] & sel;
        handshake  = bus.flush_valid & bus.flush_ready;
        old_w      = bits[bus.w_addr];
        old_c      = bits[bus.flush_set];
    end

    // Counter deltas from real bit transitions; a write to the bit being
    // cleared wins, so the clear then contributes nothing.
    always_comb begin
        up       = '0;
        dn_w     = '0;
        dn_c     = '0;
        cnt_next = cnt;
        for (int w = 0; w < WAYS; w++) begin
            up[w]   = bus.we[w] & bus.w_data & ~old_w[w];
            dn_w[w] = bus.we[w] & ~bus.w_data & old_w[w];
            dn_c[w] = handshake & bus.flush_mask[w] & old_c[w]
                      & ~(bus.we[w] & (bus.w_addr == bus.flush_set));
            cnt_next[w] = cnt[w] + CW'(up[w]) - CW'(dn_w[w]) - CW'(dn_c[w]);
        end
    end

    // Flattened counter output, dirty summaries for the selected ways and overall.
    always_comb begin
        bus.way_cnt   = '0;
        bus.any_dirty = 1'b0;
        sel_dirty     = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            bus.way_cnt[w*CW +: CW] = cnt[w];
            bus.any_dirty           = bus.any_dirty | (cnt[w] != '0);
            sel_dirty               = sel_dirty | (sel[w] & (cnt[w] != '0));
        end
    end

    // Dirty-bit storage: writes take priority over the handshake clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                bits[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (bus.we[w] && (bus.w_addr == SW'(s))) begin
                        bits[s][w] <= bus.w_data;
                    end else if (handshake && (bus.flush_set == SW'(s)) && bus.flush_mask[w]) begin
                        bits[s][w] <= 1'b0;
                    end
                end
            end
        end
    end

    // Per-way dirty-set counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                cnt[w] <= '0;
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                cnt[w] <= cnt_next[w];
            end
        end
    end

    // Flush walker FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            sel            <= '0;
            bus.flush_valid <= 1'b0;
            bus.flush_set   <= '0;
            bus.flush_mask  <= '0;
            bus.flush_busy  <= 1'b0;
            bus.flush_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        sel            <= bus.flush_sel;
                        ptr            <= '0;
                        bus.flush_busy <= 1'b1;
                        state          <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_mask != '0) begin
                        bus.flush_set   <= ptr;
                        bus.flush_mask  <= scan_mask;
                        bus.flush_valid <= 1'b1;
                        state           <= OFFER;
                    end else if ((ptr == LAST_SET) || !sel_dirty) begin
                        bus.flush_done <= 1'b1;
                        state          <= DONE;
                    end else begin
                        ptr <= ptr + SW'(1);
                    end
                end
                OFFER: begin
                    if (bus.flush_ready) begin
                        bus.flush_valid <= 1'b0;
                        if (ptr == LAST_SET) begin
                            bus.flush_done <= 1'b1;
                            state          <= DONE;
                        end else begin
                            ptr   <= ptr + SW'(1);
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    bus.flush_done <= 1'b0;
                    bus.flush_busy <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dirty_tracker.sv
// Self-checking bench for dirty_tracker: vector table, hand-written flush
// corner cases, and randomized traffic against an array-based reference model.
module tb_dirty_tracker;
    localparam int unsigned SETS = 64;
    localparam int unsigned WAYS = 2;
    localparam int unsigned SW   = 6;
    localparam int unsigned CW   = 7;

    logic clk = 1'b0;
    logic rst;

    dirty_tracker_if #(.SETS(SETS), .WAYS(WAYS)) bus ();

    dirty_tracker #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: one dirty vector per set
    logic [WAYS-1:0] mdl [SETS];
    int off_set[$];
    int off_mask[$];
    int exp_set[$];
    int exp_mask[$];

    typedef struct {
        logic [1:0] we;
        int         addr;
        logic       d;
        int         raddr;
        logic [1:0] mask;
        int         c0;
        int         c1;
        logic       any;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cnt_of(input int w);
        return int'(bus.way_cnt[w*CW +: CW]);
    endfunction

    function automatic int mdl_count(input int w);
        int c = 0;
        for (int s = 0; s < SETS; s++) if (mdl[s][w]) c++;
        return c;
    endfunction

    function automatic void mdl_write(input logic [1:0] we, input int a, input logic d);
        for (int w = 0; w < WAYS; w++) if (we[w]) mdl[a][w] = d;
    endfunction

    function automatic void mdl_clear_all();
        for (int s = 0; s < SETS; s++) mdl[s] = '0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_cnt0"}, cnt_of(0), mdl_count(0));
        check({tag, "_cnt1"}, cnt_of(1), mdl_count(1));
        check({tag, "_any"}, bus.any_dirty, (mdl_count(0) + mdl_count(1)) != 0);
    endtask

    task automatic write(input logic [1:0] we, input int a, input logic d);
        bus.we     = we;
        bus.w_addr = SW'(a);
        bus.w_data = d;
        tick();
        bus.we = '0;
        mdl_write(we, a, d);
    endtask

    task automatic check_rmask(input string tag, input int a, input logic [1:0] exp);
        bus.r_addr = SW'(a);
        #1;
        check(tag, bus.r_mask, exp);
    endtask

    // Acts as the writeback FSM for one flush; records accepted offers and
    // mirrors the clears (and an optional concurrent write) in the model.
    task automatic run_flush(input logic [1:0] sel, input int ready_pct, input int inj_set,
                             output int cycles);
        bit              finished = 0;
        bit              injected = 0;
        bit              holding  = 0;
        logic [SW-1:0]   hold_set = '0;
        logic [1:0]      hold_mask = '0;
        int              done_cnt = 0;
        off_set.delete();
        off_mask.delete();
        cycles = -1;
        bus.flush_sel = sel;
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        check("busy_after_req", bus.flush_busy, 1);
        for (int cyc = 0; cyc < 4*SETS + 20 && !finished; cyc++) begin
            if (bus.flush_done) begin
                done_cnt++;
                cycles   = cyc;
                finished = 1;
            end else begin
                if (holding) begin
                    check("offer_hold_valid", bus.flush_valid, 1);
                    check("offer_hold_set", bus.flush_set, hold_set);
                    check("offer_hold_mask", bus.flush_mask, hold_mask);
                end
                bus.flush_ready = ($urandom_range(0, 99) < ready_pct);
                if (bus.flush_valid && inj_set >= 0 && !injected && bus.flush_set == SW'(inj_set)) begin
                    bus.flush_ready = 1'b1;
                    bus.we          = 2'b10;
                    bus.w_addr      = SW'(inj_set);
                    bus.w_data      = 1'b1;
                    injected        = 1;
                end
                holding   = bus.flush_valid && !bus.flush_ready;
                hold_set  = bus.flush_set;
                hold_mask = bus.flush_mask;
                if (bus.flush_valid && bus.flush_ready) begin
                    off_set.push_back(int'(bus.flush_set));
                    off_mask.push_back(int'(bus.flush_mask));
                    mdl[bus.flush_set] = mdl[bus.flush_set] & ~bus.flush_mask;
                    if (bus.we != '0) mdl_write(bus.we, int'(bus.w_addr), bus.w_data);
                end
                tick();
                bus.we = '0;
            end
        end
        bus.flush_ready = 1'b0;
        check("flush_done_seen", done_cnt, 1);
        tick();
        check("done_pulse_end", bus.flush_done, 0);
        check("busy_end", bus.flush_busy, 0);
    endtask

    task automatic compare_offers(input string tag);
        check({tag, "_noffers"}, off_set.size(), exp_set.size());
        for (int i = 0; i < exp_set.size() && i < off_set.size(); i++) begin
            check({tag, "_set"}, off_set[i], exp_set[i]);
            check({tag, "_mask"}, off_mask[i], exp_mask[i]);
        end
    endtask

    function automatic void expect_from_model(input logic [1:0] sel);
        exp_set.delete();
        exp_mask.delete();
        for (int s = 0; s < SETS; s++) begin
            if ((mdl[s] & sel) != '0) begin
                exp_set.push_back(s);
                exp_mask.push_back(int'(mdl[s] & sel));
            end
        end
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nz;
        bit found;
        logic [1:0] sel;

        bus.we = '0; bus.w_addr = '0; bus.w_data = 1'b0; bus.r_addr = '0;
        bus.flush_req = 1'b0; bus.flush_sel = '0; bus.flush_ready = 1'b0;
        mdl_clear_all();
        rst = 1'b1;
        tick();
        tick();
        check("rst_cnt0", cnt_of(0), 0);
        check("rst_cnt1", cnt_of(1), 0);
        check("rst_any", bus.any_dirty, 0);
        check("rst_valid", bus.flush_valid, 0);
        check("rst_busy", bus.flush_busy, 0);
        check("rst_done", bus.flush_done, 0);
        check("rst_fset", bus.flush_set, 0);
        check("rst_fmask", bus.flush_mask, 0);
        rst = 1'b0;
        tick();

        // write/read/counter vectors from a clean array
        vecs[0]  = '{2'b01,  5, 1'b1,  5, 2'b01, 1, 0, 1'b1};
        vecs[1]  = '{2'b01,  5, 1'b1,  5, 2'b01, 1, 0, 1'b1};
        vecs[2]  = '{2'b10,  5, 1'b1,  5, 2'b11, 1, 1, 1'b1};
        vecs[3]  = '{2'b11,  9, 1'b1,  9, 2'b11, 2, 2, 1'b1};
        vecs[4]  = '{2'b01,  9, 1'b0,  9, 2'b10, 1, 2, 1'b1};
        vecs[5]  = '{2'b00,  9, 1'b1,  5, 2'b11, 1, 2, 1'b1};
        vecs[6]  = '{2'b10,  5, 1'b0,  5, 2'b01, 1, 1, 1'b1};
        vecs[7]  = '{2'b11,  5, 1'b0,  5, 2'b00, 0, 1, 1'b1};
        vecs[8]  = '{2'b10,  9, 1'b0,  9, 2'b00, 0, 0, 1'b0};
        vecs[9]  = '{2'b11, 63, 1'b1, 63, 2'b11, 1, 1, 1'b1};
        vecs[10] = '{2'b11,  0, 1'b1,  0, 2'b11, 2, 2, 1'b1};
        vecs[11] = '{2'b11, 63, 1'b0,  0, 2'b11, 1, 1, 1'b1};
        vecs[12] = '{2'b11,  0, 1'b0, 63, 2'b00, 0, 0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            bus.r_addr = SW'(vecs[i].raddr);
            write(vecs[i].we, vecs[i].addr, vecs[i].d);
            check("vec_rmask", bus.r_mask, vecs[i].mask);
            check("vec_cnt0", cnt_of(0), vecs[i].c0);
            check("vec_cnt1", cnt_of(1), vecs[i].c1);
            check("vec_any", bus.any_dirty, vecs[i].any);
        end

        // full flush of sets 3 and 60
        write(2'b01, 3, 1'b1);
        write(2'b11, 60, 1'b1);
        exp_set = '{3, 60};
        exp_mask = '{1, 3};
        run_flush(2'b11, 100, -1, cyc);
        compare_offers("flush_all");
        check("flush_all_cycles", cyc, 64);
        check("flush_all_cnt0", cnt_of(0), 0);
        check("flush_all_cnt1", cnt_of(1), 0);
        check("flush_all_any", bus.any_dirty, 0);

        // way-1 only flush with early exit after set 60
        write(2'b01, 3, 1'b1);
        write(2'b11, 60, 1'b1);
        exp_set = '{60};
        exp_mask = '{2};
        run_flush(2'b10, 100, -1, cyc);
        compare_offers("flush_w1");
        check("flush_w1_cycles", cyc, 63);
        check("flush_w1_cnt0", cnt_of(0), 2);
        check("flush_w1_cnt1", cnt_of(1), 0);
        check_rmask("flush_w1_r3", 3, 2'b01);
        check_rmask("flush_w1_r60", 60, 2'b01);

        // write of 1 colliding with the handshake clear
        write(2'b10, 60, 1'b1);
        exp_set = '{3, 60};
        exp_mask = '{1, 3};
        run_flush(2'b11, 100, 60, cyc);
        compare_offers("collide");
        check("collide_cnt0", cnt_of(0), 0);
        check("collide_cnt1", cnt_of(1), 1);
        check_rmask("collide_r60", 60, 2'b10);
        check_model("collide");

        // snapshot mask: bit cleared by a write while offered, no double decrement
        bus.flush_sel = 2'b10;
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bus.flush_valid) found = 1;
            else tick();
        end
        check("snap_offer_seen", found, 1);
        check("snap_set", bus.flush_set, 60);
        check("snap_mask", bus.flush_mask, 2'b10);
        write(2'b10, 60, 1'b0);
        check("snap_cnt1_after_write", cnt_of(1), 0);
        check("snap_mask_kept", bus.flush_mask, 2'b10);
        check("snap_valid_kept", bus.flush_valid, 1);
        bus.flush_ready = 1'b1;
        tick();
        bus.flush_ready = 1'b0;
        check("snap_valid_drop", bus.flush_valid, 0);
        check("snap_cnt1_no_wrap", cnt_of(1), 0);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bus.flush_done) found = 1;
            else tick();
        end
        check("snap_done_seen", found, 1);
        tick();
        check_model("snap");

        // empty flush: done one cycle after the first SCAN, busy req pulses ignored
        bus.flush_sel = 2'b11;
        bus.flush_req = 1'b1;
        tick();
        check("empty_busy", bus.flush_busy, 1);
        check("empty_done_early", bus.flush_done, 0);
        check("empty_valid0", bus.flush_valid, 0);
        tick();
        check("empty_done", bus.flush_done, 1);
        check("empty_valid1", bus.flush_valid, 0);
        tick();
        bus.flush_req = 1'b0;
        check("empty_done_drop", bus.flush_done, 0);
        check("empty_idle", bus.flush_busy, 0);
        tick();
        check("empty_req_ignored", bus.flush_busy, 0);

        // empty selection early-exits the same way
        write(2'b01, 0, 1'b1);
        exp_set.delete();
        exp_mask.delete();
        run_flush(2'b00, 100, -1, cyc);
        compare_offers("sel0");
        check("sel0_cycles", cyc, 1);
        check_model("sel0");

        // reset in the middle of an offer
        write(2'b01, 7, 1'b1);
        bus.flush_sel = 2'b11;
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bus.flush_valid) found = 1;
            else tick();
        end
        check("rstoff_offer_seen", found, 1);
        rst = 1'b1;
        #1;
        check("rstoff_cnt0", cnt_of(0), 0);
        check("rstoff_cnt1", cnt_of(1), 0);
        check("rstoff_valid", bus.flush_valid, 0);
        check("rstoff_busy", bus.flush_busy, 0);
        check("rstoff_done", bus.flush_done, 0);
        tick();
        nz = 0;
        for (int s = 0; s < SETS; s++) begin
            bus.r_addr = SW'(s);
            #0.1;
            if (bus.r_mask != '0) nz++;
        end
        check("rstoff_rmask_all", nz, 0);
        rst = 1'b0;
        mdl_clear_all();
        nz = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.flush_done) nz++;
        end
        check("rstoff_no_done", nz, 0);
        check("rstoff_idle", bus.flush_busy, 0);

        // randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                sel = 2'($urandom_range(0, 3));
                expect_from_model(sel);
                run_flush(sel, 60, -1, cyc);
                compare_offers("rnd_flush");
                check_model("rnd_flush");
            end else begin
                logic [1:0] we;
                int a;
                int ra;
                we = 2'($urandom_range(0, 3));
                a  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, SETS-1));
                ra = ($urandom_range(0, 1) == 0) ? a : int'($urandom_range(0, SETS-1));
                bus.r_addr = SW'(ra);
                write(we, a, 1'($urandom_range(0, 1)));
                check("rnd_rmask", bus.r_mask, mdl[ra]);
                check_model("rnd_wr");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
